// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU control encoder: op codes, FSM states and the
// bundle of decoder control lines.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OpNormal = 2'd0,
    OpMov    = 2'd1,
    OpInc    = 2'd2,
    OpDec    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StIssue = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef struct packed {
    logic mov_n;
    logic inc_dec_n;
    logic dec_n;
  } sel_t;

  typedef struct packed {
    logic ctrl1;
    logic internal_mov_n;
    logic address_mode_n;
    logic internal_inc_dec_n;
    logic internal_dec_n;
  } ctrl_t;

  localparam sel_t SEL_IDLE = '{mov_n: 1'b1, inc_dec_n: 1'b1, dec_n: 1'b1};

  localparam ctrl_t CTRL_IDLE = '{
    ctrl1:              1'b0,
    internal_mov_n:     1'b1,
    address_mode_n:     1'b1,
    internal_inc_dec_n: 1'b1,
    internal_dec_n:     1'b1
  };

  function automatic sel_t op_sel(input op_e op);
    sel_t sel;
    sel = SEL_IDLE;
    unique case (op)
      OpNormal: sel = SEL_IDLE;
      OpMov:    sel = '{mov_n: 1'b0, inc_dec_n: 1'b1, dec_n: 1'b1};
      OpInc:    sel = '{mov_n: 1'b0, inc_dec_n: 1'b0, dec_n: 1'b1};
      OpDec:    sel = '{mov_n: 1'b0, inc_dec_n: 1'b0, dec_n: 1'b0};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_ctrl_op_map.sv
// Combinational map from a raw 3-bit op code to the active-low internal
// select triple; codes 4-7 are flagged illegal and encoded as NORMAL.
module alu_ctrl_op_map
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] i_op,
  output sel_t       o_sel,
  output logic       o_illegal
);

  op_e w_op;

  always_comb begin
    o_illegal = i_op[2];
    w_op      = i_op[2] ? OpNormal : op_e'(i_op[1:0]);
    o_sel     = op_sel(w_op);
  end

endmodule

// File: rtl/alu_ctrl_encoder.sv
// Sequences one internal-operation request through SETUP/ISSUE/DONE, holding
// the ALU control decoder inputs stable for req_len+1 ISSUE cycles.
module alu_ctrl_encoder
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_addr_mode,
  input  logic             req_ctrl1,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
  output logic             ctrl1,
  output logic             internal_mov_n,
  output logic             address_mode_n,
  output logic             internal_inc_dec_n,
  output logic             internal_dec_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           r_state;
  state_e           w_state_d;
  sel_t             r_sel;
  logic             r_addr_mode;
  logic             r_ctrl1;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;

  sel_t             w_sel;
  logic             w_illegal;
  logic             w_accept;
  ctrl_t            w_ctrl;

  alu_ctrl_op_map u_op_map (
    .i_op      (req_op),
    .o_sel     (w_sel),
    .o_illegal (w_illegal)
  );

  assign req_ready = rst_n && (r_state == StIdle);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel       <= SEL_IDLE;
      r_addr_mode <= 1'b0;
      r_ctrl1     <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_accept && w_illegal;
      if (w_accept) begin
        r_sel       <= w_sel;
        r_addr_mode <= req_addr_mode;
        r_ctrl1     <= req_ctrl1;
        r_cnt       <= req_len;
      end else if (r_state == StIssue && r_cnt != '0) begin
        // Exit test on zero happens first, so the counter never wraps.
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StSetup;
      StSetup: w_state_d = abort ? StIdle : StIssue;
      StIssue: begin
        if (abort)            w_state_d = StIdle;
        else if (r_cnt == '0) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_IDLE;
    unique case (r_state)
      StIdle: w_ctrl = CTRL_IDLE;
      StSetup, StDone: begin
        w_ctrl.ctrl1          = r_ctrl1;
        w_ctrl.address_mode_n = ~r_addr_mode;
      end
      StIssue: begin
        w_ctrl.ctrl1              = r_ctrl1;
        w_ctrl.address_mode_n     = ~r_addr_mode;
        w_ctrl.internal_mov_n     = r_sel.mov_n;
        w_ctrl.internal_inc_dec_n = r_sel.inc_dec_n;
        w_ctrl.internal_dec_n     = r_sel.dec_n;
      end
    endcase
  end

  assign ctrl1              = w_ctrl.ctrl1;
  assign internal_mov_n     = w_ctrl.internal_mov_n;
  assign address_mode_n     = w_ctrl.address_mode_n;
  assign internal_inc_dec_n = w_ctrl.internal_inc_dec_n;
  assign internal_dec_n     = w_ctrl.internal_dec_n;
  assign busy               = (r_state != StIdle);
  assign done               = (r_state == StDone);
  assign err                = r_err;

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Scoreboard bench for alu_ctrl_encoder: stimulus pushes per-cycle expected
// output vectors, a negedge monitor pops and compares them.
module tb_alu_ctrl_encoder;

  localparam int unsigned LEN_W = 4;

  localparam logic [2:0] PhRst   = 3'd0;
  localparam logic [2:0] PhSetup = 3'd1;
  localparam logic [2:0] PhIssue = 3'd2;
  localparam logic [2:0] PhDone  = 3'd3;
  localparam logic [2:0] PhIdle  = 3'd4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic             req_addr_mode;
  logic             req_ctrl1;
  logic [LEN_W-1:0] req_len;
  logic             abort;
  logic             ctrl1;
  logic             internal_mov_n;
  logic             address_mode_n;
  logic             internal_inc_dec_n;
  logic             internal_dec_n;
  logic             busy;
  logic             done;
  logic             err;

  // {phase, ready, busy, done, err, ctrl1, mov_n, addr_mode_n, inc_dec_n, dec_n}
  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] v;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  exp_t       e;
  logic [8:0] act;

  alu_ctrl_encoder #(.LEN_W(LEN_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_addr_mode      (req_addr_mode),
    .req_ctrl1          (req_ctrl1),
    .req_len            (req_len),
    .abort              (abort),
    .ctrl1              (ctrl1),
    .internal_mov_n     (internal_mov_n),
    .address_mode_n     (address_mode_n),
    .internal_inc_dec_n (internal_inc_dec_n),
    .internal_dec_n     (internal_dec_n),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] ph, input logic rdy, input logic bsy,
                              input logic dn, input logic er, input logic c1,
                              input logic mv, input logic amn, input logic idn,
                              input logic dcn);
    exp_t r;
    r.ph = ph;
    r.v  = {rdy, bsy, dn, er, c1, mv, amn, idn, dcn};
    return r;
  endfunction

  function automatic string ph_name(input logic [2:0] ph);
    case (ph)
      PhRst:   return "reset";
      PhSetup: return "setup";
      PhIssue: return "issue";
      PhDone:  return "done";
      default: return "idle";
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {req_ready, busy, done, err, ctrl1, internal_mov_n, address_mode_n,
             internal_inc_dec_n, internal_dec_n};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s @%0t: got %b want %b (rdy,busy,done,err,c1,mov,am,id,dec)",
                 ph_name(e.ph), $time, act, e.v);
      end
    end
  end

  // Caller sits #1 after an edge in an IDLE cycle; returns #1 into the IDLE
  // cycle following DONE. sel is the hand-computed (mov_n, inc_dec_n, dec_n).
  task automatic issue(input logic [2:0] op, input logic am, input logic c1,
                       input logic [LEN_W-1:0] len, input logic [2:0] sel,
                       input logic exp_err, input logic keep_valid,
                       input logic abort_acc, input logic abort_done);
    req_valid     = 1'b1;
    req_op        = op;
    req_addr_mode = am;
    req_ctrl1     = c1;
    req_len       = len;
    abort         = abort_acc;
    @(posedge clk); #1;
    abort = 1'b0;
    q.push_back(mk(PhSetup, 1'b0, 1'b1, 1'b0, exp_err, c1, 1'b1, ~am, 1'b1, 1'b1));
    for (int i = 0; i <= int'(len); i++)
      q.push_back(mk(PhIssue, 1'b0, 1'b1, 1'b0, 1'b0, c1, sel[2], ~am, sel[1], sel[0]));
    q.push_back(mk(PhDone, 1'b0, 1'b1, 1'b1, 1'b0, c1, 1'b1, ~am, 1'b1, 1'b1));
    q.push_back(mk(PhIdle, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    // Scramble request fields while busy; they must not matter.
    req_valid     = keep_valid;
    req_op        = 3'($urandom);
    req_addr_mode = 1'($urandom);
    req_ctrl1     = 1'($urandom);
    req_len       = LEN_W'($urandom);
    repeat (int'(len) + 2) @(posedge clk);
    #1;
    abort = abort_done;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // Abort raised during the second ISSUE cycle.
  task automatic issue_abort(input logic [2:0] op, input logic am, input logic c1,
                             input logic [LEN_W-1:0] len, input logic [2:0] sel);
    req_valid     = 1'b1;
    req_op        = op;
    req_addr_mode = am;
    req_ctrl1     = c1;
    req_len       = len;
    abort         = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    q.push_back(mk(PhSetup, 1'b0, 1'b1, 1'b0, 1'b0, c1, 1'b1, ~am, 1'b1, 1'b1));
    q.push_back(mk(PhIssue, 1'b0, 1'b1, 1'b0, 1'b0, c1, sel[2], ~am, sel[1], sel[0]));
    q.push_back(mk(PhIssue, 1'b0, 1'b1, 1'b0, 1'b0, c1, sel[2], ~am, sel[1], sel[0]));
    q.push_back(mk(PhIdle, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++)
      q.push_back(mk(PhIdle, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b1;
    req_op        = 3'd3;
    req_addr_mode = 1'b0;
    req_ctrl1     = 1'b1;
    req_len       = 4'd2;
    abort         = 1'b0;

    // Three reset edges with a pending request: never ready, outputs idle.
    @(posedge clk); #1;
    q.push_back(mk(PhRst, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    q.push_back(mk(PhRst, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // DEC, len 2, accepted at the first edge after reset release.
    issue(3'd3, 1'b0, 1'b1, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // MOV with address mode, single ISSUE cycle.
    issue(3'd1, 1'b1, 1'b0, 4'd0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
    // INC with maximum length: 16 ISSUE cycles, no wrap.
    issue(3'd2, 1'b1, 1'b1, 4'd15, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    // Abort in the second ISSUE cycle of a len 5 DEC.
    issue_abort(3'd3, 1'b0, 1'b1, 4'd5, 3'b000);
    // Abort together with a request in IDLE: still accepted.
    issue(3'd0, 1'b0, 1'b1, 4'd1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
    // Illegal op: err pulse, NORMAL selects; abort in DONE is ignored.
    issue(3'd6, 1'b1, 1'b0, 4'd3, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
    // Back-to-back with req_valid held high across both requests.
    issue(3'd3, 1'b1, 1'b1, 4'd1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'd2, 1'b0, 1'b0, 4'd2, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
